// File: rtl/ntt_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ntt_loop_ctrl
// Description : Loop sequencer for iterative NTT/INTT. Walks stages, groups
//               and butterflies, emits butterfly index pairs downstream and
//               drives the twiddle unit strobes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_i, mode_i           start pulse (IDLE only), 0=NTT 1=INTT
//   busy_o, done_o            transform active, 1-cycle completion pulse
//   bf_valid_o, bf_ready_i    butterfly request handshake
//   idx_a_o, idx_b_o          butterfly top / bottom indices
//   stage_o                   current stage number
//   set_twiddle_as_psi_o      twiddle <= psi (group start)
//   update_twiddle_o          twiddle <= twiddle*omega (accepted butterfly)
//   update_omega_o            omega <= omega*omega (INTT stage end)
//   update_psi_o              psi <= omega (INTT stage end)
//   omega_idx_inc_o           omega index +1 (NTT stage end)
//   psi_idx_inc_o             psi index +1 (NTT stage end)
// ============================================================================
module ntt_loop_ctrl #(
  parameter int LOG_N      = 8,
  parameter int NUM_STAGES = LOG_N
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             bf_valid_o,
  input  logic             bf_ready_i,
  output logic [LOG_N-1:0] idx_a_o,
  output logic [LOG_N-1:0] idx_b_o,
  output logic [3:0]       stage_o,
  output logic             set_twiddle_as_psi_o,
  output logic             update_twiddle_o,
  output logic             update_omega_o,
  output logic             update_psi_o,
  output logic             omega_idx_inc_o,
  output logic             psi_idx_inc_o
);

  localparam logic [LOG_N:0]   C_N_VAL      = {1'b1, {LOG_N{1'b0}}};
  localparam logic [LOG_N:0]   C_ONE        = {{LOG_N{1'b0}}, 1'b1};
  localparam logic [3:0]       C_LAST_STAGE = 4'(NUM_STAGES - 1);
  localparam logic [3:0]       C_INTT_OFS   = 4'(LOG_N - NUM_STAGES);
  localparam logic [LOG_N-1:0] C_J_ONE      = (LOG_N)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_BFLY      = 3'd2,
    S_STAGE_END = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [3:0]       stage_q, stage_d;
  logic [LOG_N-1:0] base_q, base_d;   // first index of the current group
  logic [LOG_N-1:0] j_q, j_d;         // butterfly offset inside the group
  logic             busy_q, done_q, valid_q, load_q, se_ntt_q, se_intt_q;

  logic [LOG_N:0]   len_w;
  logic             last_j_w, last_grp_w;
  logic [LOG_N-1:0] idx_a_w, idx_b_w;

  // len is one bit wider than the indices so that 2*len == N is representable
  // when testing for the last group of a stage.
  always_comb begin
    if (mode_q) len_w = C_ONE << (stage_q + C_INTT_OFS);
    else        len_w = C_N_VAL >> (stage_q + 4'd1);
  end

  assign last_j_w   = ({1'b0, j_q} == (len_w - C_ONE));
  assign last_grp_w = (({1'b0, base_q} + (len_w << 1)) == C_N_VAL);
  assign idx_a_w    = base_q + j_q;
  assign idx_b_w    = idx_a_w + len_w[LOG_N-1:0];

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    base_d  = base_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          stage_d = '0;
          base_d  = '0;
          j_d     = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_BFLY;
      S_BFLY: begin
        if (bf_ready_i) begin
          if (last_j_w) begin
            j_d = '0;
            if (last_grp_w) begin
              base_d  = '0;
              state_d = S_STAGE_END;
            end else begin
              // Not the last group, so 2*len < N and truncation is safe.
              base_d  = base_q + (LOG_N)'(len_w << 1);
              state_d = S_LOAD;
            end
          end else begin
            j_d = j_q + C_J_ONE;
          end
        end
      end
      S_STAGE_END: begin
        stage_d = stage_q + 4'd1;
        state_d = (stage_q == C_LAST_STAGE) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        stage_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so they line up with
  // the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      stage_q   <= '0;
      base_q    <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
      se_ntt_q  <= 1'b0;
      se_intt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      stage_q   <= stage_d;
      base_q    <= base_d;
      j_q       <= j_d;
      busy_q    <= (state_d == S_LOAD) || (state_d == S_BFLY) || (state_d == S_STAGE_END);
      done_q    <= (state_d == S_DONE);
      valid_q   <= (state_d == S_BFLY);
      load_q    <= (state_d == S_LOAD);
      se_ntt_q  <= (state_d == S_STAGE_END) && !mode_d;
      se_intt_q <= (state_d == S_STAGE_END) && mode_d;
    end
  end

  // Index counters must never run past N-1.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == S_BFLY)) begin
      assert (32'(base_q) + 32'(j_q) + 32'(len_w) < 32'(C_N_VAL));
    end
  end

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign bf_valid_o           = valid_q;
  assign idx_a_o              = valid_q ? idx_a_w : '0;
  assign idx_b_o              = valid_q ? idx_b_w : '0;
  assign stage_o              = stage_q;
  assign set_twiddle_as_psi_o = load_q;
  assign update_twiddle_o     = valid_q & bf_ready_i;
  assign update_omega_o       = se_intt_q;
  assign update_psi_o         = se_intt_q;
  assign omega_idx_inc_o      = se_ntt_q;
  assign psi_idx_inc_o        = se_ntt_q;

endmodule
`default_nettype wire
